decode_writeback: RTL

//  Y86-64 SEQ decode + writeback stage. Consumes icode/rA/rB from fetch, selects srcA/srcB,

---
 rtl/decode_writeback_pkg.sv | 56 +++++
 rtl/decode_writeback_if.sv | 32 +++
 rtl/decode_writeback_regfile.sv | 56 +++++
 rtl/decode_writeback.sv | 94 +++++++++
 4 files changed

// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 decode/writeback types, register IDs and the src/dst selection function.
package decode_writeback_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned NREG   = 15;
    localparam int unsigned ID_W   = 4;

    typedef logic [ID_W-1:0] reg_id_t;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

    typedef enum logic [3:0] {
        ICODE_HALT   = 4'h0,
        ICODE_NOP    = 4'h1,
        ICODE_RRMOVQ = 4'h2,
        ICODE_IRMOVQ = 4'h3,
        ICODE_RMMOVQ = 4'h4,
        ICODE_MRMOVQ = 4'h5,
        ICODE_OPQ    = 4'h6,
        ICODE_JXX    = 4'h7,
        ICODE_CALL   = 4'h8,
        ICODE_RET    = 4'h9,
        ICODE_PUSHQ  = 4'hA,
        ICODE_POPQ   = 4'hB
    } icode_e;

    typedef struct packed {
        reg_id_t src_a;
        reg_id_t src_b;
        reg_id_t dst_e;
        reg_id_t dst_m;
    } dec_ids_t;

    // Register-ID selection per instruction class; unknown icodes select nothing.
    function automatic dec_ids_t decode_ids(input logic [3:0] icode,
                                            input reg_id_t    ra,
                                            input reg_id_t    rb);
        dec_ids_t d;
        d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (icode)
            ICODE_RRMOVQ: begin d.src_a = ra;   d.dst_e = rb; end
            ICODE_IRMOVQ: begin d.dst_e = rb; end
            ICODE_RMMOVQ: begin d.src_a = ra;   d.src_b = rb; end
            ICODE_MRMOVQ: begin d.src_b = rb;   d.dst_m = ra; end
            ICODE_OPQ:    begin d.src_a = ra;   d.src_b = rb;   d.dst_e = rb; end
            ICODE_CALL:   begin d.src_b = RRSP; d.dst_e = RRSP; end
            ICODE_RET:    begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; end
            ICODE_PUSHQ:  begin d.src_a = ra;   d.src_b = RRSP; d.dst_e = RRSP; end
            ICODE_POPQ:   begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; d.dst_m = ra; end
            default:      ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Fetch/execute-facing signal bundle for the decode/writeback stage.
interface decode_writeback_if #(
    parameter int unsigned DATA_W = 64
);
    logic              dec_en;
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              wb_en;
    logic              cnd;
    logic              stat_ok;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_val;

    modport master (
        output dec_en, icode, rA, rB, wb_en, cnd, stat_ok, valE, valM, dbg_sel,
        input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );

    modport slave (
        input  dec_en, icode, rA, rB, wb_en, cnd, stat_ok, valE, valM, dbg_sel,
        output srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );
endinterface

// File: rtl/decode_writeback_regfile.sv
// 15-entry architectural register file: two decode read ports, one debug read port,
// E and M write ports with M taking priority on a shared ID.
module decode_writeback_regfile
    import decode_writeback_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_e,
    input  reg_id_t           id_e,
    input  logic [DATA_W-1:0] data_e,
    input  logic              we_m,
    input  reg_id_t           id_m,
    input  logic [DATA_W-1:0] data_m,
    input  reg_id_t           rd_id_a,
    output logic [DATA_W-1:0] rd_a,
    input  reg_id_t           rd_id_b,
    output logic [DATA_W-1:0] rd_b,
    input  reg_id_t           rd_id_dbg,
    output logic [DATA_W-1:0] rd_dbg
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= (4'(i) == RRSP) ? RSP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (we_m && id_m == 4'(i)) begin
                    regs[i] <= data_m;
                end else if (we_e && id_e == 4'(i)) begin
                    regs[i] <= data_e;
                end
            end
        end
    end

    // IDs outside 0..NREG-1 (notably RNONE) read as zero.
    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        rd_dbg = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (rd_id_a   == 4'(i)) rd_a   = regs[i];
            if (rd_id_b   == 4'(i)) rd_b   = regs[i];
            if (rd_id_dbg == 4'(i)) rd_dbg = regs[i];
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode + writeback: selects source/destination IDs, registers operand reads
// with write-through from a same-edge writeback, and commits valE/valM to the register file.
module decode_writeback
    import decode_writeback_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input logic              clk,
    input logic              rst,
    decode_writeback_if.slave bus
);

    dec_ids_t          ids_n;
    dec_ids_t          ids_q;
    logic [3:0]        icode_q;
    logic [DATA_W-1:0] val_a_q;
    logic [DATA_W-1:0] val_b_q;

    logic              wr_ok;
    reg_id_t           dst_e_eff;
    logic              we_e;
    logic              we_m;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign ids_n = decode_ids(bus.icode, bus.rA, bus.rB);

    // Writes use IDs latched by the previous decode; a failed cmov drops its E write.
    assign wr_ok     = bus.wb_en && bus.stat_ok;
    assign dst_e_eff = (icode_q == ICODE_RRMOVQ && !bus.cnd) ? RNONE : ids_q.dst_e;
    assign we_e      = wr_ok && (dst_e_eff != RNONE);
    assign we_m      = wr_ok && (ids_q.dst_m != RNONE);

    decode_writeback_regfile #(
        .DATA_W   (DATA_W),
        .NREG     (NREG),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_e      (we_e),
        .id_e      (dst_e_eff),
        .data_e    (bus.valE),
        .we_m      (we_m),
        .id_m      (ids_q.dst_m),
        .data_m    (bus.valM),
        .rd_id_a   (ids_n.src_a),
        .rd_a      (rf_a),
        .rd_id_b   (ids_n.src_b),
        .rd_b      (rf_b),
        .rd_id_dbg (bus.dbg_sel),
        .rd_dbg    (bus.dbg_val)
    );

    // Write-through so a decode sharing the edge with a writeback sees the new value.
    always_comb begin
        fwd_a = rf_a;
        fwd_b = rf_b;
        if (ids_n.src_a != RNONE) begin
            if (we_m && ids_n.src_a == ids_q.dst_m)   fwd_a = bus.valM;
            else if (we_e && ids_n.src_a == dst_e_eff) fwd_a = bus.valE;
        end
        if (ids_n.src_b != RNONE) begin
            if (we_m && ids_n.src_b == ids_q.dst_m)   fwd_b = bus.valM;
            else if (we_e && ids_n.src_b == dst_e_eff) fwd_b = bus.valE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ids_q   <= '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
            icode_q <= ICODE_HALT;
            val_a_q <= '0;
            val_b_q <= '0;
        end else if (bus.dec_en) begin
            ids_q   <= ids_n;
            icode_q <= bus.icode;
            val_a_q <= fwd_a;
            val_b_q <= fwd_b;
        end
    end

    assign bus.srcA = ids_q.src_a;
    assign bus.srcB = ids_q.src_b;
    assign bus.dstE = ids_q.dst_e;
    assign bus.dstM = ids_q.dst_m;
    assign bus.valA = val_a_q;
    assign bus.valB = val_b_q;

endmodule
